// File: rtl/systolic_tile_sequencer.sv
// -----------------------------------------------------------------------------
// systolic_tile_sequencer
//
// Sequences one tile of an N x N FP8 systolic MAC array:
//   - fetches K operand vectors (A columns, B rows) from external memories,
//   - drives them onto the west (A) and north (B) array edges with a diagonal
//     skew so that PE(i,j) sees step k on cycle 2+k+i+j,
//   - issues a per-PE clear wavefront so each PE's first product loads its
//     accumulator,
//   - waits for the array to drain, latches the BF16 result bus and offers it
//     to a consumer over a valid/ready handshake.
//
// Cycle 0 is the first cycle after the edge that accepts start in IDLE.
//   FETCH   : cycles 0..K-1, rd_en=1, rd_addr=cycle
//   DRAIN   : cycles K..K+2N
//   CAPTURE : cycle K+2N+1, res_data <= c_in at its closing edge
//   HOLD    : res_valid=1 from cycle K+2N+2 until res_valid&&res_ready
// A start with k_len=0 skips fetch and clears and presents res_data=0 on
// cycle 1.
//
// Optional build macro:
//   SEQ_ACC_CHAIN_EN - adds input acc_chain (sampled with start). When set,
//                      the tile issues no pe_clear pulses so the array keeps
//                      accumulating onto the previous tile's sums.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, k_len          tile request and K, sampled only in IDLE
//   acc_chain             (SEQ_ACC_CHAIN_EN only) suppress the clear wavefront
//   busy                  high from accepted start until result handshake
//   rd_en, rd_addr        operand memory read strobe and index k
//   rd_a_data, rd_b_data  A column / B row vector k, valid cycle after rd_en
//   a_edge, b_edge        skewed FP8 operands, lane i/j at [8*i +: 8]
//   pe_clear              clear for PE(i,j) at bit i*N+j
//   c_in                  BF16 result bus from the array, PE(i,j) at i*N+j
//   res_data, res_valid   latched tile result and its valid flag
//   res_ready             consumer accepts res_data
// -----------------------------------------------------------------------------
module systolic_tile_sequencer #(
  parameter int N   = 2,
  parameter int K_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [K_W-1:0]      k_len,
`ifdef SEQ_ACC_CHAIN_EN
  input  logic                acc_chain,
`endif
  output logic                busy,
  output logic                rd_en,
  output logic [K_W-1:0]      rd_addr,
  input  logic [8*N-1:0]      rd_a_data,
  input  logic [8*N-1:0]      rd_b_data,
  output logic [8*N-1:0]      a_edge,
  output logic [8*N-1:0]      b_edge,
  output logic [N*N-1:0]      pe_clear,
  input  logic [16*N*N-1:0]   c_in,
  output logic [16*N*N-1:0]   res_data,
  output logic                res_valid,
  input  logic                res_ready
);

  // Cycle counter must reach K+2N+1 with K up to 2^K_W-1.
  localparam int CNT_W = K_W + $clog2(2*N + 2) + 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DRAIN   = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;

  logic [2:0]          state_q,    state_d;
  logic [CNT_W-1:0]    cnt_q,      cnt_d;
  logic [K_W-1:0]      k_q,        k_d;
  logic                zero_q,     zero_d;
  logic                clr_en_q,   clr_en_d;
  logic                rd_en_q,    rd_en_d;
  logic [K_W-1:0]      rd_addr_q,  rd_addr_d;
  logic                rd_vld_q;
  logic [N*N-1:0]      pe_clear_q, pe_clear_d;
  logic [16*N*N-1:0]   res_data_q, res_data_d;

  logic                clr_req;
  logic [CNT_W-1:0]    drain_last;

`ifdef SEQ_ACC_CHAIN_EN
  assign clr_req = ~acc_chain;
`else
  assign clr_req = 1'b1;
`endif

  // Last DRAIN cycle index; CAPTURE follows on K+2N+1.
  assign drain_last = CNT_W'(k_q) + CNT_W'(2*N);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer latches.
    state_d    = state_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    zero_d     = zero_q;
    clr_en_d   = clr_en_q;
    rd_en_d    = rd_en_q;
    rd_addr_d  = rd_addr_q;
    res_data_d = res_data_q;
    pe_clear_d = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d    = '0;
          k_d      = k_len;
          clr_en_d = clr_req;
          if (k_len == '0) begin
            // Empty tile: no reads, no clears, result of zero on cycle 1.
            zero_d  = 1'b1;
            state_d = S_CAPTURE;
          end else begin
            zero_d    = 1'b0;
            rd_en_d   = 1'b1;
            rd_addr_d = '0;
            state_d   = S_FETCH;
          end
        end
      end

      S_FETCH: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (rd_addr_q == k_q - K_W'(1)) begin
          rd_en_d = 1'b0;
          state_d = S_DRAIN;
        end else begin
          rd_addr_d = rd_addr_q + K_W'(1);
        end
      end

      S_DRAIN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == drain_last) begin
          state_d = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        res_data_d = zero_q ? '0 : c_in;
        state_d    = S_HOLD;
      end

      S_HOLD: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Clear wavefront: PE(i,j) pulses on cycle 2+i+j, i.e. it is registered
    // on the edge closing cycle 1+i+j. Only FETCH/DRAIN can cover those
    // cycles, and only tiles with K>=1 get there.
    if ((state_q == S_FETCH || state_q == S_DRAIN) && clr_en_q) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (cnt_q == CNT_W'(i + j + 1)) begin
            pe_clear_d[i*N + j] = 1'b1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      k_q        <= '0;
      zero_q     <= 1'b0;
      clr_en_q   <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      rd_vld_q   <= 1'b0;
      pe_clear_q <= '0;
      res_data_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      zero_q     <= zero_d;
      clr_en_q   <= clr_en_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      rd_vld_q   <= rd_en_q;  // memory data is valid one cycle after rd_en
      pe_clear_q <= pe_clear_d;
      res_data_q <= res_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Skew pipelines: lane g has one output register plus g extra stages, so
  // data returned on cycle k+1 appears on the edge at cycle 2+k+g. Lanes are
  // forced to FP8 zero whenever no read data is returning so idle PEs add 0.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < N; g++) begin : g_lane
    logic [7:0] a_pipe_q [0:g];
    logic [7:0] b_pipe_q [0:g];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        // NOTE: these small register arrays are reset explicitly because the
        // edges must present FP8 zero immediately after reset; large storage
        // arrays would normally be left unreset.
        for (int m = 0; m <= g; m++) begin
          a_pipe_q[m] <= 8'h00;
          b_pipe_q[m] <= 8'h00;
        end
      end else begin
        a_pipe_q[0] <= rd_vld_q ? rd_a_data[8*g +: 8] : 8'h00;
        b_pipe_q[0] <= rd_vld_q ? rd_b_data[8*g +: 8] : 8'h00;
        for (int m = 1; m <= g; m++) begin
          a_pipe_q[m] <= a_pipe_q[m-1];
          b_pipe_q[m] <= b_pipe_q[m-1];
        end
      end
    end

    assign a_edge[8*g +: 8] = a_pipe_q[g];
    assign b_edge[8*g +: 8] = b_pipe_q[g];
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy      = (state_q != S_IDLE);
  assign res_valid = (state_q == S_HOLD);
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign pe_clear  = pe_clear_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// -----------------------------------------------------------------------------
// tb_systolic_tile_sequencer
//
// Directed bench for systolic_tile_sequencer with N=2, K_W=8. A small memory
// model answers reads one cycle after rd_en and returns junk otherwise. The
// first K=3 tile is checked cycle by cycle from a vector table; later tiles
// (result hold, back-to-back start, mid-tile reset, K=0, optional acc_chain)
// use hand-written sequences with a small timing model.
// -----------------------------------------------------------------------------
module tb_systolic_tile_sequencer;

  localparam int N   = 2;
  localparam int K_W = 8;

  logic                clk       = 1'b0;
  logic                rst_n     = 1'b0;
  logic                start     = 1'b0;
  logic [K_W-1:0]      k_len     = '0;
`ifdef SEQ_ACC_CHAIN_EN
  logic                acc_chain = 1'b0;
`endif
  logic                busy;
  logic                rd_en;
  logic [K_W-1:0]      rd_addr;
  logic [8*N-1:0]      rd_a_data = '0;
  logic [8*N-1:0]      rd_b_data = '0;
  logic [8*N-1:0]      a_edge;
  logic [8*N-1:0]      b_edge;
  logic [N*N-1:0]      pe_clear;
  logic [16*N*N-1:0]   c_in      = '0;
  logic [16*N*N-1:0]   res_data;
  logic                res_valid;
  logic                res_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem_a [0:7];
  logic [15:0] mem_b [0:7];

  systolic_tile_sequencer #(.N(N), .K_W(K_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .k_len     (k_len),
`ifdef SEQ_ACC_CHAIN_EN
    .acc_chain (acc_chain),
`endif
    .busy      (busy),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_a_data (rd_a_data),
    .rd_b_data (rd_b_data),
    .a_edge    (a_edge),
    .b_edge    (b_edge),
    .pe_clear  (pe_clear),
    .c_in      (c_in),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready)
  );

  always #5 clk = ~clk;

  // Operand memory: one-cycle read latency, junk when not reading so that an
  // ungated skew path shows up on the edges.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_a_data <= mem_a[rd_addr[2:0]];
      rd_b_data <= mem_b[rd_addr[2:0]];
    end else begin
      rd_a_data <= 16'hDEAD;
      rd_b_data <= 16'hBEEF;
    end
  end

  typedef struct {
    logic [15:0] a;      // expected a_edge
    logic [15:0] b;      // expected b_edge
    logic [3:0]  clr;    // expected pe_clear
    logic        rd_en;  // expected rd_en
    logic [7:0]  addr;   // expected rd_addr when rd_en
    logic        valid;  // expected res_valid
    logic        cap;    // res_data must hold the cycle-8 c_in value
  } vec_t;

  vec_t tbl [0:10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] cin_of(input int c);
    return 64'hA000_B000_C000_D000 + 64'(c);
  endfunction

  // Expected skewed edge word at cycle c of a K=k tile.
  function automatic logic [15:0] edge_model(input int c, input int k, input logic is_a);
    logic [15:0] w;
    logic [15:0] ent;
    int kk;
    w = '0;
    for (int i = 0; i < N; i++) begin
      kk = c - 2 - i;
      if (kk >= 0 && kk < k) begin
        ent = is_a ? mem_a[kk] : mem_b[kk];
        w[8*i +: 8] = ent[8*i +: 8];
      end
    end
    return w;
  endfunction

  // Runs a K>=1 tile from an IDLE cycle through its handshake.
  task automatic run_tile(input int k, input logic [63:0] cval, input logic chain, input string tag);
    int cap;
    logic [3:0] exp_clr;
    cap = k + 2*N + 1;
    start = 1'b1;
    k_len = K_W'(k);
`ifdef SEQ_ACC_CHAIN_EN
    acc_chain = chain;
`endif
    step();
    start = 1'b0;
    for (int c = 0; c <= cap + 1; c++) begin
      c_in = (c == cap) ? cval : ~cval;
      exp_clr = '0;
      if (!chain) begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            if (c == 2 + i + j) exp_clr[i*N + j] = 1'b1;
      end
      check($sformatf("%s rd_en c%0d", tag, c), 64'(rd_en), 64'(c < k));
      if (c < k) check($sformatf("%s rd_addr c%0d", tag, c), 64'(rd_addr), 64'(c));
      check($sformatf("%s pe_clear c%0d", tag, c), 64'(pe_clear), 64'(exp_clr));
      check($sformatf("%s a_edge c%0d", tag, c), 64'(a_edge), 64'(edge_model(c, k, 1'b1)));
      check($sformatf("%s b_edge c%0d", tag, c), 64'(b_edge), 64'(edge_model(c, k, 1'b0)));
      check($sformatf("%s busy c%0d", tag, c), 64'(busy), 64'(1));
      check($sformatf("%s res_valid c%0d", tag, c), 64'(res_valid), 64'(c == cap + 1));
      if (c <= cap) step();
    end
    check($sformatf("%s res_data", tag), res_data, cval);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check($sformatf("%s busy after hs", tag), 64'(busy), 64'(0));
    check($sformatf("%s res_valid after hs", tag), 64'(res_valid), 64'(0));
`ifdef SEQ_ACC_CHAIN_EN
    acc_chain = 1'b0;
`endif
  endtask

  initial begin
    mem_a[0] = 16'h3938; mem_a[1] = 16'h4140; mem_a[2] = 16'h4948; mem_a[3] = 16'h2C2B;
    mem_a[4] = 16'h1E1D; mem_a[5] = 16'h5A5B; mem_a[6] = 16'h6C6D; mem_a[7] = 16'h7E7F;
    mem_b[0] = 16'h3A38; mem_b[1] = 16'h3A38; mem_b[2] = 16'h3230; mem_b[3] = 16'h4443;
    mem_b[4] = 16'h5655; mem_b[5] = 16'h6766; mem_b[6] = 16'h7877; mem_b[7] = 16'h1211;

    //              a_edge    b_edge    clr      rd  addr valid cap
    tbl[0]  = '{16'h0000, 16'h0000, 4'b0000, 1'b1, 8'd0, 1'b0, 1'b0};
    tbl[1]  = '{16'h0000, 16'h0000, 4'b0000, 1'b1, 8'd1, 1'b0, 1'b0};
    tbl[2]  = '{16'h0038, 16'h0038, 4'b0001, 1'b1, 8'd2, 1'b0, 1'b0};
    tbl[3]  = '{16'h3940, 16'h3A38, 4'b0110, 1'b0, 8'd0, 1'b0, 1'b0};
    tbl[4]  = '{16'h4148, 16'h3A30, 4'b1000, 1'b0, 8'd0, 1'b0, 1'b0};
    tbl[5]  = '{16'h4900, 16'h3200, 4'b0000, 1'b0, 8'd0, 1'b0, 1'b0};
    tbl[6]  = '{16'h0000, 16'h0000, 4'b0000, 1'b0, 8'd0, 1'b0, 1'b0};
    tbl[7]  = '{16'h0000, 16'h0000, 4'b0000, 1'b0, 8'd0, 1'b0, 1'b0};
    tbl[8]  = '{16'h0000, 16'h0000, 4'b0000, 1'b0, 8'd0, 1'b0, 1'b0};
    tbl[9]  = '{16'h0000, 16'h0000, 4'b0000, 1'b0, 8'd0, 1'b1, 1'b1};
    tbl[10] = '{16'h0000, 16'h0000, 4'b0000, 1'b0, 8'd0, 1'b1, 1'b1};

    // ---- reset state ----
    #2;
    check("reset busy", 64'(busy), 64'(0));
    check("reset rd_en", 64'(rd_en), 64'(0));
    check("reset rd_addr", 64'(rd_addr), 64'(0));
    check("reset a_edge", 64'(a_edge), 64'(0));
    check("reset b_edge", 64'(b_edge), 64'(0));
    check("reset pe_clear", 64'(pe_clear), 64'(0));
    check("reset res_valid", 64'(res_valid), 64'(0));
    check("reset res_data", res_data, 64'(0));
    @(posedge clk);
    #2 rst_n = 1'b1;
    step();

    // ---- K=3 tile, cycle-by-cycle from the vector table ----
    start = 1'b1;
    k_len = 8'd3;
    step();
    start = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      c_in = cin_of(c);
      check($sformatf("t1 a_edge c%0d", c), 64'(a_edge), 64'(tbl[c].a));
      check($sformatf("t1 b_edge c%0d", c), 64'(b_edge), 64'(tbl[c].b));
      check($sformatf("t1 pe_clear c%0d", c), 64'(pe_clear), 64'(tbl[c].clr));
      check($sformatf("t1 rd_en c%0d", c), 64'(rd_en), 64'(tbl[c].rd_en));
      if (tbl[c].rd_en) check($sformatf("t1 rd_addr c%0d", c), 64'(rd_addr), 64'(tbl[c].addr));
      check($sformatf("t1 busy c%0d", c), 64'(busy), 64'(1));
      check($sformatf("t1 res_valid c%0d", c), 64'(res_valid), 64'(tbl[c].valid));
      check($sformatf("t1 res_data c%0d", c), res_data, tbl[c].cap ? cin_of(8) : 64'(0));
      if (c < 10) step();
    end

    // ---- hold with res_ready=0, c_in toggling, start ignored ----
    for (int h = 0; h < 10; h++) begin
      step();
      c_in  = ~cin_of(h);
      start = (h % 2 == 0);
      k_len = 8'd3;
      check($sformatf("hold rd_en h%0d", h), 64'(rd_en), 64'(0));
      check($sformatf("hold busy h%0d", h), 64'(busy), 64'(1));
      check($sformatf("hold res_valid h%0d", h), 64'(res_valid), 64'(1));
      check($sformatf("hold res_data h%0d", h), res_data, cin_of(8));
    end
    start = 1'b0;
    step();
    check("hold rd_en final", 64'(rd_en), 64'(0));
    check("hold res_data final", res_data, cin_of(8));
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("hs busy", 64'(busy), 64'(0));
    check("hs res_valid", 64'(res_valid), 64'(0));

    // ---- next start accepted right after the handshake ----
    run_tile(1, 64'h1234_5678_9ABC_DEF0, 1'b0, "b2b");

    // ---- asynchronous reset on cycle 4 of a K=5 tile ----
    start = 1'b1;
    k_len = 8'd5;
    step();
    start = 1'b0;
    for (int c = 0; c < 4; c++) step();
    check("rst pre rd_en", 64'(rd_en), 64'(1));
    check("rst pre pe_clear", 64'(pe_clear), 64'(4'b1000));
    #2 rst_n = 1'b0;
    #1;
    check("rst busy", 64'(busy), 64'(0));
    check("rst rd_en", 64'(rd_en), 64'(0));
    check("rst rd_addr", 64'(rd_addr), 64'(0));
    check("rst a_edge", 64'(a_edge), 64'(0));
    check("rst b_edge", 64'(b_edge), 64'(0));
    check("rst pe_clear", 64'(pe_clear), 64'(0));
    check("rst res_valid", 64'(res_valid), 64'(0));
    check("rst res_data", res_data, 64'(0));
    @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    run_tile(1, 64'h0BAD_F00D_CAFE_0001, 1'b0, "post_rst");

    // ---- K=0: straight to HOLD with a zero result on cycle 1 ----
    start = 1'b1;
    k_len = 8'd0;
    step();
    start = 1'b0;
    c_in  = 64'hFFFF_FFFF_FFFF_FFFF;
    check("k0 c0 busy", 64'(busy), 64'(1));
    check("k0 c0 rd_en", 64'(rd_en), 64'(0));
    check("k0 c0 pe_clear", 64'(pe_clear), 64'(0));
    check("k0 c0 res_valid", 64'(res_valid), 64'(0));
    step();
    check("k0 c1 res_valid", 64'(res_valid), 64'(1));
    check("k0 c1 res_data", res_data, 64'(0));
    check("k0 c1 rd_en", 64'(rd_en), 64'(0));
    check("k0 c1 pe_clear", 64'(pe_clear), 64'(0));
    check("k0 c1 busy", 64'(busy), 64'(1));
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("k0 hs busy", 64'(busy), 64'(0));
    check("k0 hs res_valid", 64'(res_valid), 64'(0));

`ifdef SEQ_ACC_CHAIN_EN
    // ---- accumulate-chain tile: same timing, no clear wavefront ----
    run_tile(2, 64'h5555_AAAA_3333_CCCC, 1'b0, "chain0");
    run_tile(2, 64'h6666_9999_1111_EEEE, 1'b1, "chain1");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
